// File: rtl/kpn_pkg.sv
// -----------------------------------------------------------------------------
// kpn_pkg
// Shared types and constants for the KPN add/sub process node.
//   kpn_state_t  : process FSM states
//   OP_ADD/OP_SUB: op_sel encodings
//   DEFAULT_BITS : default token width
// -----------------------------------------------------------------------------
package kpn_pkg;

  localparam int DEFAULT_BITS = 16;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  typedef enum logic [1:0] {
    S_WAIT_IN  = 2'd0,
    S_CAPTURE  = 2'd1,
    S_EXEC     = 2'd2,
    S_WAIT_OUT = 2'd3
  } kpn_state_t;

endpackage

// File: rtl/kpn_alu.sv
// -----------------------------------------------------------------------------
// kpn_alu
// Combinational two's-complement add/subtract on sign-extended BITS_NUMBER+1
// bits, returning a BITS_NUMBER-bit result.
//   a, b : signed operands
//   op   : OP_ADD (a+b) or OP_SUB (a-b)
//   y    : result; wraps by default
// Build option: define KPN_SATURATE_EN to clamp a signed overflow to the most
// positive / most negative BITS_NUMBER value instead of wrapping.
// -----------------------------------------------------------------------------
module kpn_alu
  import kpn_pkg::*;
#(
  parameter int BITS_NUMBER = DEFAULT_BITS
) (
  input  logic [BITS_NUMBER-1:0] a,
  input  logic [BITS_NUMBER-1:0] b,
  input  logic                   op,
  output logic [BITS_NUMBER-1:0] y
);

`ifdef KPN_SATURATE_EN
  localparam bit SATURATE = 1'b1;
`else
  localparam bit SATURATE = 1'b0;
`endif

  localparam logic [BITS_NUMBER-1:0] MAX_POS = {1'b0, {(BITS_NUMBER-1){1'b1}}};
  localparam logic [BITS_NUMBER-1:0] MAX_NEG = {1'b1, {(BITS_NUMBER-1){1'b0}}};

  logic [BITS_NUMBER:0] a_ext;
  logic [BITS_NUMBER:0] b_ext;
  logic [BITS_NUMBER:0] full;
  logic                 overflow;

  always_comb begin
    // NOTE: every signal written here gets a value on every path (default
    // first), so no latch is inferred.
    a_ext    = {a[BITS_NUMBER-1], a};
    b_ext    = {b[BITS_NUMBER-1], b};
    full     = (op == OP_SUB) ? (a_ext - b_ext) : (a_ext + b_ext);
    // The extra bit disagrees with the result sign only when the true value
    // does not fit in BITS_NUMBER bits; the extra bit is then the true sign.
    overflow = full[BITS_NUMBER] ^ full[BITS_NUMBER-1];
    y        = full[BITS_NUMBER-1:0];
    if (SATURATE && overflow) begin
      y = full[BITS_NUMBER] ? MAX_NEG : MAX_POS;
    end
  end

endmodule

// File: rtl/kpn_add_sub_process.sv
// -----------------------------------------------------------------------------
// kpn_add_sub_process
// KPN process node between FIFO stages: blocking-reads one token from each of
// FIFO A and FIFO B, adds or subtracts them, and blocking-writes the result to
// the downstream FIFO. One token per 4 cycles at best.
// Ports:
//   clk, rst_n         : clock, asynchronous active-low reset
//   a_empty/a_data/a_rd: FIFO A flag, read data (valid cycle after a_rd), strobe
//   b_empty/b_data/b_rd: FIFO B flag, read data (valid cycle after b_rd), strobe
//   op_sel             : OP_ADD / OP_SUB, sampled in S_CAPTURE
//   out_full/out_wr    : output FIFO full flag and write strobe
//   out_data           : registered result token
//   busy               : high in every state except S_WAIT_IN
//   token_cnt          : results written since reset, wraps
// Build option: KPN_SATURATE_EN selects saturating arithmetic (see kpn_alu).
// -----------------------------------------------------------------------------
module kpn_add_sub_process
  import kpn_pkg::*;
#(
  parameter int BITS_NUMBER = DEFAULT_BITS,
  parameter int COUNT_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   a_empty,
  input  logic [BITS_NUMBER-1:0] a_data,
  output logic                   a_rd,
  input  logic                   b_empty,
  input  logic [BITS_NUMBER-1:0] b_data,
  output logic                   b_rd,
  input  logic                   op_sel,
  input  logic                   out_full,
  output logic                   out_wr,
  output logic [BITS_NUMBER-1:0] out_data,
  output logic                   busy,
  output logic [COUNT_WIDTH-1:0] token_cnt
);

  kpn_state_t             state;
  logic [BITS_NUMBER-1:0] opa_q;
  logic [BITS_NUMBER-1:0] opb_q;
  logic                   op_q;
  logic [BITS_NUMBER-1:0] result_q;
  logic [COUNT_WIDTH-1:0] cnt_q;
  logic [BITS_NUMBER-1:0] alu_y;
  logic                   rd_go;
  logic                   wr_go;

  kpn_alu #(
    .BITS_NUMBER (BITS_NUMBER)
  ) u_alu (
    .a  (opa_q),
    .b  (opb_q),
    .op (op_q),
    .y  (alu_y)
  );

  // Strobes are decoded from the state register and the flags of the same
  // cycle: the FIFO read data must be present in S_CAPTURE, so the read has to
  // be issued in S_WAIT_IN itself. The decode is gated by rst_n so that a
  // reset drops every strobe at once, even in the middle of a cycle.
  assign rd_go  = rst_n && (state == S_WAIT_IN)  && !a_empty && !b_empty;
  assign wr_go  = rst_n && (state == S_WAIT_OUT) && !out_full;

  assign a_rd      = rd_go;
  assign b_rd      = rd_go;
  assign out_wr    = wr_go;
  assign busy      = (state != S_WAIT_IN);
  assign out_data  = result_q;
  assign token_cnt = cnt_q;

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values of the others.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_WAIT_IN;
      opa_q    <= '0;
      opb_q    <= '0;
      op_q     <= OP_ADD;
      result_q <= '0;
      cnt_q    <= '0;
    end else begin
      unique case (state)
        S_WAIT_IN: begin
          // Paired blocking read: one empty input holds back both.
          if (!a_empty && !b_empty) begin
            state <= S_CAPTURE;
          end
        end
        S_CAPTURE: begin
          opa_q <= a_data;
          opb_q <= b_data;
          op_q  <= op_sel;
          state <= S_EXEC;
        end
        S_EXEC: begin
          result_q <= alu_y;
          state    <= S_WAIT_OUT;
        end
        S_WAIT_OUT: begin
          // result_q is held untouched while stalled on out_full.
          if (!out_full) begin
            cnt_q <= cnt_q + 1'b1;
            state <= S_WAIT_IN;
          end
        end
        default: state <= S_WAIT_IN;
      endcase
    end
  end

endmodule

// File: tb/tb_kpn_add_sub_process.sv
// -----------------------------------------------------------------------------
// tb_kpn_add_sub_process
// Self-checking bench for kpn_add_sub_process. The two input FIFOs and the
// output FIFO are modelled with queues; a reference model computes each result
// from the popped operands with plain integer arithmetic. Honours
// KPN_SATURATE_EN in the same way as the design.
// -----------------------------------------------------------------------------
module tb_kpn_add_sub_process;

  localparam int BW = 16;
  localparam int CW = 4;   // small counter so the wrap is reached quickly

  logic          clk;
  logic          rst_n;
  logic          a_empty;
  logic [BW-1:0] a_data;
  logic          a_rd;
  logic          b_empty;
  logic [BW-1:0] b_data;
  logic          b_rd;
  logic          op_sel;
  logic          out_full;
  logic          out_wr;
  logic [BW-1:0] out_data;
  logic          busy;
  logic [CW-1:0] token_cnt;

  kpn_add_sub_process #(
    .BITS_NUMBER (BW),
    .COUNT_WIDTH (CW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .a_empty   (a_empty),
    .a_data    (a_data),
    .a_rd      (a_rd),
    .b_empty   (b_empty),
    .b_data    (b_data),
    .b_rd      (b_rd),
    .op_sel    (op_sel),
    .out_full  (out_full),
    .out_wr    (out_wr),
    .out_data  (out_data),
    .busy      (busy),
    .token_cnt (token_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // Environment: FIFO models and event recording
  // ---------------------------------------------------------------------------
  logic [BW-1:0] fa_q[$];
  logic [BW-1:0] fb_q[$];
  logic [BW-1:0] exp_q[$];
  logic [BW-1:0] got_q[$];
  int            rd_cyc_q[$];
  int            wr_cyc_q[$];
  int            cyc;
  int            pair_err;
  int            overlap_err;
  int            full_wr_err;
  bit            cap_pend;
  logic [BW-1:0] cap_a;
  logic [BW-1:0] cap_b;
  int            sent;

  int tests;
  int fails;

  // Reference result: exact integer value, then wrap or clamp to 16 bits.
  function automatic logic [BW-1:0] ref_result(input logic [BW-1:0] a,
                                                input logic [BW-1:0] b,
                                                input logic          sub);
    int sa;
    int sb;
    int r;
    sa = $signed(a);
    sb = $signed(b);
    r  = sub ? (sa - sb) : (sa + sb);
`ifdef KPN_SATURATE_EN
    if (r > 32767)  r = 32767;
    if (r < -32768) r = -32768;
`endif
    return r[BW-1:0];
  endfunction

  function automatic logic [BW-1:0] got_at(input int i);
    return (i < got_q.size()) ? got_q[i] : 'x;
  endfunction

  function automatic logic [BW-1:0] exp_at(input int i);
    return (i < exp_q.size()) ? exp_q[i] : 'x;
  endfunction

  // Empty flags follow queue occupancy, updated just after each falling edge.
  always @(negedge clk) begin
    #1;
    a_empty = (fa_q.size() == 0);
    b_empty = (fb_q.size() == 0);
  end

  always @(posedge clk) begin
    cyc++;
    // op_sel at the edge after the read is the one the node captures.
    if (cap_pend) begin
      exp_q.push_back(ref_result(cap_a, cap_b, op_sel));
      cap_pend = 1'b0;
    end
    if (a_rd !== b_rd) pair_err++;
    if (a_rd && out_wr) overlap_err++;
    if (out_wr && out_full) full_wr_err++;
    if (a_rd && b_rd) begin
      if (fa_q.size() == 0 || fb_q.size() == 0) begin
        pair_err++;
      end else begin
        cap_a = fa_q.pop_front();
        cap_b = fb_q.pop_front();
        a_data <= cap_a;
        b_data <= cap_b;
        cap_pend = 1'b1;
        rd_cyc_q.push_back(cyc);
      end
    end
    if (out_wr) begin
      got_q.push_back(out_data);
      wr_cyc_q.push_back(cyc);
    end
  end

  // ---------------------------------------------------------------------------
  // Helpers (stimulus and bounded waits)
  // ---------------------------------------------------------------------------
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push_pair(input logic [BW-1:0] a, input logic [BW-1:0] b);
    fa_q.push_back(a);
    fb_q.push_back(b);
    sent++;
  endtask

  task automatic wait_writes(input int n, input int budget, input string tag);
    int k;
    k = 0;
    while (got_q.size() < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    tests++;
    if (got_q.size() < n) begin
      fails++;
      $display("FAIL %s_timeout: writes=%0d required=%0d", tag, got_q.size(), n);
    end
  endtask

  task automatic wait_reads(input int n, input int budget, input string tag);
    int k;
    k = 0;
    while (rd_cyc_q.size() < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    tests++;
    if (rd_cyc_q.size() < n) begin
      fails++;
      $display("FAIL %s_timeout: reads=%0d required=%0d", tag, rd_cyc_q.size(), n);
    end
  endtask

  task automatic clear_env();
    fa_q.delete();
    fb_q.delete();
    exp_q.delete();
    got_q.delete();
    rd_cyc_q.delete();
    wr_cyc_q.delete();
    cap_pend = 1'b0;
    sent     = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n    = 1'b0;
    out_full = 1'b0;
    tick(3);
    clear_env();
    tick(1);
    rst_n = 1'b1;
    tick(1);
  endtask

  // ---------------------------------------------------------------------------
  // Tests
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    // Tokens are waiting while reset is held: no strobe may leak out.
    @(negedge clk);
    rst_n = 1'b0;
    fa_q.push_back(16'd1);
    fb_q.push_back(16'd2);
    tick(1);
    #2;
    tests++; if (a_rd !== 1'b0)     begin fails++; $display("FAIL rst_a_rd: got %b want 0", a_rd); end
    tests++; if (b_rd !== 1'b0)     begin fails++; $display("FAIL rst_b_rd: got %b want 0", b_rd); end
    tests++; if (out_wr !== 1'b0)   begin fails++; $display("FAIL rst_out_wr: got %b want 0", out_wr); end
    tests++; if (busy !== 1'b0)     begin fails++; $display("FAIL rst_busy: got %b want 0", busy); end
    tests++; if (out_data !== '0)   begin fails++; $display("FAIL rst_out_data: got %h want 0", out_data); end
    tests++; if (token_cnt !== '0)  begin fails++; $display("FAIL rst_token_cnt: got %0d want 0", token_cnt); end
    do_reset();
  endtask

  task automatic test_basic_add();
    int n0;
    int r0;
    n0 = got_q.size();
    r0 = rd_cyc_q.size();
    op_sel = 1'b0;
    push_pair(16'd5, 16'd3);
    wait_writes(n0 + 1, 30, "add");
    tick(2);
    tests++; if (got_at(n0) !== 16'd8) begin fails++; $display("FAIL add_data: got %h want 0008", got_at(n0)); end
    tests++; if (rd_cyc_q.size() !== r0 + 1) begin fails++; $display("FAIL add_reads: got %0d want %0d", rd_cyc_q.size(), r0 + 1); end
    // Read strobe in the first cycle of the 4-cycle transaction, write in the last.
    tests++;
    if (rd_cyc_q.size() <= r0 || wr_cyc_q.size() <= n0 || (wr_cyc_q[n0] - rd_cyc_q[r0]) != 3) begin
      fails++;
      $display("FAIL add_latency: got %0d want 3",
               (rd_cyc_q.size() > r0 && wr_cyc_q.size() > n0) ? wr_cyc_q[n0] - rd_cyc_q[r0] : -1);
    end
    tests++; if (token_cnt !== CW'(1)) begin fails++; $display("FAIL add_token_cnt: got %0d want 1", token_cnt); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL add_idle_busy: got %b want 0", busy); end
  endtask

  task automatic test_sub();
    int n0;
    n0 = got_q.size();
    op_sel = 1'b1;
    push_pair(16'd3, 16'd10);
    wait_writes(n0 + 1, 30, "sub");
    tick(1);
    tests++; if (got_at(n0) !== 16'hFFF9) begin fails++; $display("FAIL sub_data: got %h want fff9", got_at(n0)); end
    tests++; if (token_cnt !== CW'(sent)) begin fails++; $display("FAIL sub_token_cnt: got %0d want %0d", token_cnt, sent); end
  endtask

  task automatic test_overflow();
    int            n0;
    logic [BW-1:0] want_add;
    logic [BW-1:0] want_sub;
`ifdef KPN_SATURATE_EN
    want_add = 16'h7FFF;
    want_sub = 16'h8000;
`else
    want_add = 16'h8000;
    want_sub = 16'h7FFF;
`endif
    n0 = got_q.size();
    op_sel = 1'b0;
    push_pair(16'h7FFF, 16'h0001);
    wait_writes(n0 + 1, 30, "ovf_add");
    op_sel = 1'b1;
    push_pair(16'h8000, 16'h0001);
    wait_writes(n0 + 2, 30, "ovf_sub");
    tick(1);
    tests++; if (got_at(n0) !== want_add)     begin fails++; $display("FAIL ovf_add: got %h want %h", got_at(n0), want_add); end
    tests++; if (got_at(n0 + 1) !== want_sub) begin fails++; $display("FAIL ovf_sub: got %h want %h", got_at(n0 + 1), want_sub); end
  endtask

  task automatic test_blocking_read();
    int n0;
    int r0;
    bit busy_seen;
    n0 = got_q.size();
    r0 = rd_cyc_q.size();
    busy_seen = 1'b0;
    op_sel = 1'b0;
    fa_q.push_back(16'd100);
    repeat (10) begin
      @(negedge clk);
      if (busy !== 1'b0) busy_seen = 1'b1;
    end
    tests++; if (rd_cyc_q.size() !== r0) begin fails++; $display("FAIL blk_no_read: reads got %0d want %0d", rd_cyc_q.size(), r0); end
    tests++; if (busy_seen) begin fails++; $display("FAIL blk_busy: got 1 want 0"); end
    fb_q.push_back(16'd23);
    sent++;
    wait_writes(n0 + 1, 30, "blk");
    tests++; if (rd_cyc_q.size() !== r0 + 1) begin fails++; $display("FAIL blk_one_read: got %0d want %0d", rd_cyc_q.size(), r0 + 1); end
    tests++; if (got_at(n0) !== 16'd123) begin fails++; $display("FAIL blk_data: got %h want 007b", got_at(n0)); end
  endtask

  task automatic test_stall();
    int            n0;
    int            r0;
    logic [BW-1:0] hold;
    bit            moved;
    n0 = got_q.size();
    r0 = rd_cyc_q.size();
    op_sel   = 1'b0;
    out_full = 1'b1;
    push_pair(16'd7, 16'd8);
    push_pair(16'd1, 16'd1);
    wait_reads(r0 + 1, 30, "stall_rd");
    tick(2);  // now in S_WAIT_OUT
    hold  = out_data;
    moved = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (out_data !== hold) moved = 1'b1;
    end
    tests++; if (got_q.size() !== n0) begin fails++; $display("FAIL stall_no_wr: writes got %0d want %0d", got_q.size(), n0); end
    tests++; if (moved) begin fails++; $display("FAIL stall_stable: out_data moved from %h", hold); end
    tests++; if (out_data !== 16'd15) begin fails++; $display("FAIL stall_data: got %h want 000f", out_data); end
    tests++; if (rd_cyc_q.size() !== r0 + 1) begin fails++; $display("FAIL stall_no_rd: reads got %0d want %0d", rd_cyc_q.size(), r0 + 1); end
    tests++; if (busy !== 1'b1) begin fails++; $display("FAIL stall_busy: got %b want 1", busy); end
    out_full = 1'b0;
    @(negedge clk);
    tests++; if (got_q.size() !== n0 + 1) begin fails++; $display("FAIL stall_release: writes got %0d want %0d", got_q.size(), n0 + 1); end
    wait_writes(n0 + 2, 30, "stall_2nd");
    tick(6);
    tests++; if (got_q.size() !== n0 + 2) begin fails++; $display("FAIL stall_wr_count: got %0d want %0d", got_q.size(), n0 + 2); end
    tests++; if (got_at(n0 + 1) !== 16'd2) begin fails++; $display("FAIL stall_data2: got %h want 0002", got_at(n0 + 1)); end
    tests++; if (token_cnt !== CW'(sent)) begin fails++; $display("FAIL stall_token_cnt: got %0d want %0d", token_cnt, sent); end
  endtask

  task automatic test_random();
    int n0;
    int nt;
    bit done;
    int bad;
    n0   = got_q.size();
    nt   = 40;
    done = 1'b0;
    fork
      begin
        for (int i = 0; i < nt; i++) begin
          logic [BW-1:0] a;
          logic [BW-1:0] b;
          a = BW'($urandom);
          b = BW'($urandom);
          case ($urandom_range(0, 5))
            0: a = 16'h7FFF;
            1: a = 16'h8000;
            2: b = 16'h8000;
            default: ;
          endcase
          if ($urandom_range(0, 1) == 1) begin
            push_pair(a, b);
          end else begin
            fa_q.push_back(a);
            tick($urandom_range(0, 3));
            fb_q.push_back(b);
            sent++;
          end
          tick($urandom_range(0, 6));
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(negedge clk);
          op_sel   = 1'($urandom_range(0, 1));
          out_full = ($urandom_range(0, 3) == 0);
        end
        out_full = 1'b0;
      end
    join
    wait_writes(n0 + nt, 2000, "rand");
    tick(6);
    bad = 0;
    for (int i = n0; i < n0 + nt; i++) begin
      tests++;
      if (got_at(i) !== exp_at(i)) begin
        fails++;
        bad++;
        if (bad <= 8) $display("FAIL rand_data[%0d]: got %h want %h", i, got_at(i), exp_at(i));
      end
    end
    tests++; if (got_q.size() !== exp_q.size()) begin fails++; $display("FAIL rand_count: writes %0d want %0d", got_q.size(), exp_q.size()); end
    tests++; if (token_cnt !== CW'(sent)) begin fails++; $display("FAIL rand_token_cnt: got %0d want %0d", token_cnt, CW'(sent)); end
  endtask

  task automatic test_reset_mid();
    int r0;
    r0 = rd_cyc_q.size();
    op_sel   = 1'b0;
    out_full = 1'b1;
    push_pair(16'd9, 16'd9);
    wait_reads(r0 + 1, 30, "rmid_rd");
    tick(2);  // stalled in S_WAIT_OUT
    tests++; if (busy !== 1'b1) begin fails++; $display("FAIL rmid_pre_busy: got %b want 1", busy); end
    rst_n    = 1'b0;
    out_full = 1'b0;
    #1;
    tests++; if (out_wr !== 1'b0)    begin fails++; $display("FAIL rmid_out_wr: got %b want 0", out_wr); end
    tests++; if (busy !== 1'b0)      begin fails++; $display("FAIL rmid_busy: got %b want 0", busy); end
    tests++; if (token_cnt !== '0)   begin fails++; $display("FAIL rmid_token_cnt: got %0d want 0", token_cnt); end
    tick(2);
    clear_env();
    tick(1);
    rst_n = 1'b1;
    tick(10);
    tests++; if (got_q.size() !== 0) begin fails++; $display("FAIL rmid_extra_wr: writes got %0d want 0", got_q.size()); end
    tests++; if (busy !== 1'b0)      begin fails++; $display("FAIL rmid_resume_idle: busy %b want 0", busy); end
    // Normal operation resumes from S_WAIT_IN.
    op_sel = 1'b1;
    push_pair(16'd50, 16'd8);
    wait_writes(1, 30, "rmid_after");
    tick(1);
    tests++; if (got_at(0) !== 16'd42) begin fails++; $display("FAIL rmid_after_data: got %h want 002a", got_at(0)); end
    tests++; if (token_cnt !== CW'(1)) begin fails++; $display("FAIL rmid_after_cnt: got %0d want 1", token_cnt); end
  endtask

  task automatic test_protocol();
    tests++; if (pair_err != 0)    begin fails++; $display("FAIL proto_pair: %0d unpaired or empty reads, want 0", pair_err); end
    tests++; if (overlap_err != 0) begin fails++; $display("FAIL proto_overlap: %0d rd/wr overlaps, want 0", overlap_err); end
    tests++; if (full_wr_err != 0) begin fails++; $display("FAIL proto_full_wr: %0d writes while full, want 0", full_wr_err); end
  endtask

  initial begin
    tests       = 0;
    fails       = 0;
    cyc         = 0;
    pair_err    = 0;
    overlap_err = 0;
    full_wr_err = 0;
    cap_pend    = 1'b0;
    sent        = 0;
    rst_n       = 1'b0;
    a_empty     = 1'b1;
    b_empty     = 1'b1;
    a_data      = '0;
    b_data      = '0;
    op_sel      = 1'b0;
    out_full    = 1'b0;
    tick(2);

    test_reset();
    test_basic_add();
    test_sub();
    test_overflow();
    test_blocking_read();
    test_stall();
    test_random();
    test_reset_mid();
    test_protocol();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule
